// File: rtl/button_toggle_pkg.sv
// Shared types and defaults for the BTN1 debounce/toggle stage.
// The state encoding is shared with segment_decoder and the board top.
package button_toggle_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } btn_state_e;

  // 10 ms at the 12 MHz board oscillator
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 120000;
  localparam int unsigned CNT_WIDTH_DEFAULT       = 17;

  typedef struct packed {
    logic selector;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
  } btn_out_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs.
// Async active-high reset clears both stages.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_toggle.sv
// Debounces BTN1 and turns each accepted press into a selector toggle,
// with one-cycle press/release strobes for other consumers.
module button_toggle
  import button_toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN1,
  output logic selector,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s2;
  btn_state_e           state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  btn_out_t             out_q, out_n;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk(CLK),
    .rst(RST),
    .d  (BTN1),
    .q  (s2)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RELEASED;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      out_q <= out_n;
    end
  end

  // Next state; the counter only runs in the two pending states
  always_comb begin
    state_n             = state;
    cnt_n               = cnt;
    out_n               = out_q;
    out_n.press_pulse   = 1'b0;
    out_n.release_pulse = 1'b0;
    case (state)
      RELEASED: begin
        if (s2) begin
          state_n = PRESS_PENDING;
          cnt_n   = '0;
        end
      end
      PRESS_PENDING: begin
        if (!s2) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n           = PRESSED;
          cnt_n             = '0;
          out_n.pressed     = 1'b1;
          out_n.press_pulse = 1'b1;
          out_n.selector    = ~out_q.selector;
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_n = RELEASE_PENDING;
          cnt_n   = '0;
        end
      end
      RELEASE_PENDING: begin
        if (s2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n             = RELEASED;
          cnt_n               = '0;
          out_n.pressed       = 1'b0;
          out_n.release_pulse = 1'b1;
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_n = RELEASED;
        cnt_n   = '0;
      end
    endcase
  end

  assign selector      = out_q.selector;
  assign pressed       = out_q.pressed;
  assign press_pulse   = out_q.press_pulse;
  assign release_pulse = out_q.release_pulse;

endmodule
